// File: rtl/contador_pkg.sv
// -----------------------------------------------------------------------------
// contador_pkg
//
// Shared types and constants for the parametrised up/down counter.
//   dir_e              : count direction (DIR_DOWN = 0, DIR_UP = 1)
//   mode_e             : terminal behaviour (MODE_WRAP = 0, MODE_SAT = 1)
//   CONTADOR_MAX_WIDTH : widest counter that may be built
// -----------------------------------------------------------------------------
package contador_pkg;

    localparam int CONTADOR_MAX_WIDTH = 32;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage

// File: rtl/contador_prescaler.sv
// -----------------------------------------------------------------------------
// contador_prescaler
//
// Divides the count enable by PRESCALE. The internal counter advances only
// while en is high and holds while en is low. tick is high while the counter
// sits at PRESCALE-1. The counter then returns to 0 on the next enabled edge.
//
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous reset, active-low
//   en   in   count enable
//   clr  in   synchronous clear of the prescaler (counter clear or load)
//   tick out  high on the enabled cycle that completes a prescale period
// -----------------------------------------------------------------------------
module contador_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    assign tick = (pre_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/contador_param.sv
// -----------------------------------------------------------------------------
// contador_param
//
// Parametrised up/down counter with the following features:
//   - modulo MAX+1 counting
//   - wrap or saturate at the ends
//   - synchronous clear and load (the load value is clamped to MAX)
//   - a one-cycle terminal-count pulse
//   - a sticky overflow/underflow flag
// Action priority on each edge is clr, then load, then step, then hold.
//
// Optional feature: define CONTADOR_PRESCALE_EN to divide the enable by
// PRESCALE through contador_prescaler. Without it the counter steps on every
// enabled edge and PRESCALE has no effect.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-low
//   en        in   count enable
//   up_dn     in   1 = count up, 0 = count down
//   sat       in   0 = wrap, 1 = saturate
//   clr       in   synchronous clear
//   load      in   synchronous load of load_val
//   load_val  in   value to load (clamped to MAX)
//   count     out  current count
//   tc        out  terminal-count pulse, one cycle after a terminal step
//   ovf       out  sticky flag, set by any terminal step
// -----------------------------------------------------------------------------
module contador_param
    import contador_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // Reject illegal parameter values when the design is elaborated.
    generate
        if (WIDTH < 1 || WIDTH > CONTADOR_MAX_WIDTH) begin : g_bad_width
            $error("contador_param: WIDTH must be 1..32");
        end
        if (MAX < 1 || MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
            $error("contador_param: MAX must be 1..2**WIDTH-1");
        end
        if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
            $error("contador_param: PRESCALE must be 2..65535");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic             tick;
    logic             step;
    logic             going_up;
    logic             saturating;
    logic             terminal;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] load_clamped;

`ifdef CONTADOR_PRESCALE_EN
    // Both clear and load restart the prescale period.
    contador_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (clr | load),
        .tick(tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign step         = en & tick;
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    // A terminal step is one taken from the end of the range in the current
    // direction. It is the same condition in both modes. Only the resulting
    // count differs: wrap to the other end, or stay where it is.
    always_comb begin
        going_up   = (dir_e'(up_dn) == DIR_UP);
        saturating = (mode_e'(sat) == MODE_SAT);
        terminal   = going_up ? (count == MAX_V) : (count == '0);
        next_count = count;
        if (going_up) begin
            if (!terminal) begin
                next_count = count + WIDTH'(1);
            end else if (!saturating) begin
                next_count = '0;
            end
        end else begin
            if (!terminal) begin
                next_count = count - WIDTH'(1);
            end else if (!saturating) begin
                next_count = MAX_V;
            end
        end
    end

    // tc is cleared on every edge that is not a terminal step, so it lasts
    // exactly one cycle. ovf is only set here. Only clr and rst clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            tc    <= 1'b0;
        end else if (step) begin
            count <= next_count;
            tc    <= terminal;
            if (terminal) begin
                ovf <= 1'b1;
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_contador_param.sv
// -----------------------------------------------------------------------------
// tb_contador_param
//
// Self-checking bench for contador_param. It uses two instances:
//   dut_a : WIDTH = 8, MAX = 99
//   dut_b : WIDTH = 4, MAX = 9
// Each stimulus record pushes its expected response onto a scoreboard queue.
// The response is popped and compared one clock later, after the edge.
// Prints "<passed>/<total> checks passed" at the end.
// Define CONTADOR_PRESCALE_EN to run the prescaler sequence instead of the
// single-step vectors.
// -----------------------------------------------------------------------------
module tb_contador_param;

    typedef struct packed {
        logic       en;
        logic       up_dn;
        logic       sat;
        logic       clr;
        logic       load;
        logic [7:0] load_val;
    } stim_t;

    typedef struct packed {
        logic [7:0] count;
        logic       tc;
        logic       ovf;
    } resp_t;

    typedef struct packed {
        logic  sel;
        stim_t s;
        resp_t r;
    } vec_t;

    localparam stim_t IDLE = '0;

    logic clk = 1'b0;
    logic rst;
    stim_t stim_a = '0;
    stim_t stim_b = '0;
    logic [7:0] count_a;
    logic       tc_a;
    logic       ovf_a;
    logic [3:0] count_b;
    logic       tc_b;
    logic       ovf_b;
    logic       unused_hi;

    int n_checks = 0;
    int n_pass   = 0;

    resp_t exp_q[$];
    string name_q[$];
    bit    sel_q[$];
    vec_t  vecs[$];

    always #5 clk = ~clk;

    assign unused_hi = |stim_b.load_val[7:4];

    contador_param #(.WIDTH(8), .MAX(99), .PRESCALE(4)) dut_a (
        .clk(clk), .rst(rst), .en(stim_a.en), .up_dn(stim_a.up_dn),
        .sat(stim_a.sat), .clr(stim_a.clr), .load(stim_a.load),
        .load_val(stim_a.load_val), .count(count_a), .tc(tc_a), .ovf(ovf_a)
    );

    contador_param #(.WIDTH(4), .MAX(9), .PRESCALE(4)) dut_b (
        .clk(clk), .rst(rst), .en(stim_b.en), .up_dn(stim_b.up_dn),
        .sat(stim_b.sat), .clr(stim_b.clr), .load(stim_b.load),
        .load_val(stim_b.load_val[3:0]), .count(count_b), .tc(tc_b), .ovf(ovf_b)
    );

    function automatic stim_t st(input logic en, input logic up, input logic sat,
                                 input logic clr, input logic load, input int lv);
        stim_t s;
        s.en = en; s.up_dn = up; s.sat = sat; s.clr = clr; s.load = load;
        s.load_val = 8'(lv);
        return s;
    endfunction

    function automatic resp_t rs(input int cnt, input logic tc, input logic ovf);
        resp_t r;
        r.count = 8'(cnt); r.tc = tc; r.ovf = ovf;
        return r;
    endfunction

    function automatic vec_t mk(input logic sel, input stim_t s, input resp_t r);
        vec_t v;
        v.sel = sel; v.s = s; v.r = r;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Compare the oldest scoreboard entry against the DUT it was aimed at.
    task automatic checkOutput();
        resp_t e;
        string n;
        bit    sel;
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        sel = sel_q.pop_front();
        if (sel) begin
            checkField({n, ".count_b"}, {4'b0, count_b}, e.count);
            checkField({n, ".tc_b"},    {7'b0, tc_b},    {7'b0, e.tc});
            checkField({n, ".ovf_b"},   {7'b0, ovf_b},   {7'b0, e.ovf});
        end else begin
            checkField({n, ".count_a"}, count_a,         e.count);
            checkField({n, ".tc_a"},    {7'b0, tc_a},    {7'b0, e.tc});
            checkField({n, ".ovf_a"},   {7'b0, ovf_a},   {7'b0, e.ovf});
        end
    endtask

    // Drive one DUT for one clock while the other idles.
    task automatic applyStimulus(input bit sel, input stim_t s, input resp_t e,
                                 input string name);
        if (sel) begin
            stim_b = s;
            stim_a = IDLE;
        end else begin
            stim_a = s;
            stim_b = IDLE;
        end
        exp_q.push_back(e);
        name_q.push_back(name);
        sel_q.push_back(sel);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;

        // Asynchronous reset state, before any clock edge.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        checkField("reset.count_a", count_a, 8'd0);
        checkField("reset.tc_a",    {7'b0, tc_a},  8'd0);
        checkField("reset.ovf_a",   {7'b0, ovf_a}, 8'd0);
        checkField("reset.count_b", {4'b0, count_b}, 8'd0);
        checkField("reset.ovf_b",   {7'b0, ovf_b}, 8'd0);
        @(negedge clk);
        rst = 1'b1;

`ifdef CONTADOR_PRESCALE_EN
        // Prescale by 4: the count moves on the 4th, 8th and 12th enabled cycle.
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b0, st(1, 1, 0, 0, 0, 0), rs(i / 4, 0, 0),
                          $sformatf("pre_%0d", i));
        end
        // Two enabled cycles, two held, two enabled: the next increment is
        // two cycles later than it would be without the gap.
        applyStimulus(1'b0, st(1, 1, 0, 0, 0, 0), rs(3, 0, 0), "gap_en1");
        applyStimulus(1'b0, st(1, 1, 0, 0, 0, 0), rs(3, 0, 0), "gap_en2");
        applyStimulus(1'b0, st(0, 1, 0, 0, 0, 0), rs(3, 0, 0), "gap_off1");
        applyStimulus(1'b0, st(0, 1, 0, 0, 0, 0), rs(3, 0, 0), "gap_off2");
        applyStimulus(1'b0, st(1, 1, 0, 0, 0, 0), rs(3, 0, 0), "gap_en3");
        applyStimulus(1'b0, st(1, 1, 0, 0, 0, 0), rs(4, 0, 0), "gap_en4");
        // Load clears the prescaler, so a full period is needed again.
        applyStimulus(1'b0, st(1, 1, 0, 0, 1, 50), rs(50, 0, 0), "pre_load");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, st(1, 1, 0, 0, 0, 0), rs(50 + i / 4, 0, 0),
                          $sformatf("pre_after_load_%0d", i));
        end
`else
        // Pulse reset in the middle of a count, then count up from 0.
        applyStimulus(1'b0, st(0, 0, 0, 0, 1, 37), rs(37, 0, 0), "load37");
        applyStimulus(1'b0, st(1, 1, 0, 0, 0, 0),  rs(38, 0, 0), "step38");
        rst    = 1'b0;
        stim_a = st(1, 1, 0, 0, 0, 0);
        #1;
        checkField("rst_mid.count_a", count_a, 8'd0);
        checkField("rst_mid.tc_a",    {7'b0, tc_a},  8'd0);
        checkField("rst_mid.ovf_a",   {7'b0, ovf_a}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, st(1, 1, 0, 0, 0, 0), rs(i, 0, 0),
                          $sformatf("release_%0d", i));
        end

        // dut_b (MAX = 9): wrap up from 0 over ten steps.
        for (int i = 1; i <= 9; i++) begin
            vecs.push_back(mk(1'b1, st(1, 1, 0, 0, 0, 0), rs(i, 0, 0)));
        end
        vecs.push_back(mk(1'b1, st(1, 1, 0, 0, 0, 0), rs(0, 1, 1)));
        vecs.push_back(mk(1'b1, st(0, 1, 0, 0, 0, 0), rs(0, 0, 1)));
        vecs.push_back(mk(1'b1, st(1, 0, 0, 0, 0, 0), rs(9, 1, 1)));
        // dut_b saturate up, then saturate down at 0.
        vecs.push_back(mk(1'b1, st(0, 0, 0, 1, 0, 0), rs(0, 0, 0)));
        vecs.push_back(mk(1'b1, st(0, 1, 1, 0, 1, 8), rs(8, 0, 0)));
        vecs.push_back(mk(1'b1, st(1, 1, 1, 0, 0, 0), rs(9, 0, 0)));
        vecs.push_back(mk(1'b1, st(1, 1, 1, 0, 0, 0), rs(9, 1, 1)));
        vecs.push_back(mk(1'b1, st(1, 1, 1, 0, 0, 0), rs(9, 1, 1)));
        vecs.push_back(mk(1'b1, st(0, 0, 1, 0, 1, 0), rs(0, 0, 1)));
        vecs.push_back(mk(1'b1, st(1, 0, 1, 0, 0, 0), rs(0, 1, 1)));
        vecs.push_back(mk(1'b1, st(0, 0, 1, 0, 0, 0), rs(0, 0, 1)));
        // Load is clamped to MAX. Mode and direction may change on any step.
        vecs.push_back(mk(1'b1, st(0, 0, 0, 0, 1, 15), rs(9, 0, 1)));
        vecs.push_back(mk(1'b1, st(1, 0, 1, 0, 0, 0),  rs(8, 0, 1)));
        vecs.push_back(mk(1'b1, st(1, 1, 0, 0, 0, 0),  rs(9, 0, 1)));
        vecs.push_back(mk(1'b1, st(1, 1, 0, 0, 0, 0),  rs(0, 1, 1)));
        // Load on a terminal step wins: no tc, and ovf is not set.
        vecs.push_back(mk(1'b1, st(1, 1, 0, 1, 0, 0), rs(0, 0, 0)));
        vecs.push_back(mk(1'b1, st(0, 1, 0, 0, 1, 9), rs(9, 0, 0)));
        vecs.push_back(mk(1'b1, st(1, 1, 0, 0, 1, 3), rs(3, 0, 0)));
        vecs.push_back(mk(1'b1, st(0, 1, 0, 0, 0, 0), rs(3, 0, 0)));
        // dut_a (MAX = 99): clamp, wrap, clear-beats-load, hold, down wrap.
        vecs.push_back(mk(1'b0, st(0, 1, 0, 0, 1, 200), rs(99, 0, 0)));
        vecs.push_back(mk(1'b0, st(1, 1, 0, 0, 0, 0),   rs(0, 1, 1)));
        vecs.push_back(mk(1'b0, st(1, 1, 0, 1, 1, 5),   rs(0, 0, 0)));
        vecs.push_back(mk(1'b0, st(0, 1, 0, 0, 1, 50),  rs(50, 0, 0)));
        vecs.push_back(mk(1'b0, st(0, 1, 0, 0, 0, 0),   rs(50, 0, 0)));
        vecs.push_back(mk(1'b0, st(1, 0, 0, 0, 0, 0),   rs(49, 0, 0)));
        vecs.push_back(mk(1'b0, st(1, 0, 0, 0, 1, 0),   rs(0, 0, 0)));
        vecs.push_back(mk(1'b0, st(1, 0, 0, 0, 0, 0),   rs(99, 1, 1)));
        vecs.push_back(mk(1'b0, st(1, 0, 0, 0, 0, 0),   rs(98, 0, 1)));
        vecs.push_back(mk(1'b0, st(0, 0, 0, 0, 1, 255), rs(99, 0, 1)));
        vecs.push_back(mk(1'b0, st(1, 1, 0, 1, 0, 0),   rs(0, 0, 0)));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v.sel, v.s, v.r, $sformatf("vec%0d", i));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
